// File: rtl/dma_cmd_issuer_if.sv
// Host command port and BA-engine start/status bundle for dma_cmd_issuer.
// The master modport is the issuer's view; slave is the host/engine side.
interface dma_cmd_issuer_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_src_i;
  logic [ADDR_W-1:0] cmd_dst_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              start_o;
  logic [ADDR_W-1:0] src_addr_o;
  logic [ADDR_W-1:0] dst_addr_o;
  logic [LEN_W-1:0]  byte_len_o;
  logic              idle_i;
  logic              done_i;
  logic              busy_o;
  logic              irq_o;
  logic [7:0]        cmp_cnt_o;
  logic              err_o;
  logic              err_clr_i;

  modport master (
    input  cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    input  idle_i, done_i, err_clr_i,
    output cmd_ready_o, start_o, src_addr_o, dst_addr_o, byte_len_o,
    output busy_o, irq_o, cmp_cnt_o, err_o
  );

  modport slave (
    output cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    output idle_i, done_i, err_clr_i,
    input  cmd_ready_o, start_o, src_addr_o, dst_addr_o, byte_len_o,
    input  busy_o, irq_o, cmp_cnt_o, err_o
  );
endinterface

// File: rtl/dma_cmd_issuer.sv
// Queues host copy commands and issues them one at a time to the BA engine,
// tracking each transfer through the engine's idle/done levels.
module dma_cmd_issuer #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  dma_cmd_issuer_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int ENT_W = 2 * ADDR_W + LEN_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_START     = 3'd2,
    S_BUSY      = 3'd3,
    S_CPL       = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ack_q, ack_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [7:0]        cmp_q, cmp_d;
  logic              start_q, start_d;
  logic              irq_q, irq_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              push_s;
  logic              pop_s;
  logic              head_zero_s;
  logic              tmo_hit_s;
  logic              cpl_s;
  logic [ENT_W-1:0]  head_s;

  // FIFO control: push/pop qualification, pointer and occupancy updates.
  always_comb begin
    push_s      = bus.cmd_valid_i && (count_q != CNT_W'(DEPTH));
    pop_s       = (state_q == S_IDLE) && (count_q != {CNT_W{1'b0}});
    head_s      = mem_q[rd_ptr_q];
    head_zero_s = (head_s[LEN_W-1:0] == {LEN_W{1'b0}});
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {bus.cmd_src_i, bus.cmd_dst_i, bus.cmd_len_i};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Transfer tracking terms used by both next-state and output logic.
  always_comb begin
    cpl_s     = ack_q && bus.done_i;
    tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYC - 2));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d = head_zero_s ? S_CPL : S_WAIT_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (bus.idle_i) begin
          state_d = S_START;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (cpl_s) begin
          state_d = S_CPL;
        end else if (tmo_hit_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_CPL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic; host-visible outputs are registered from the
  // next state so they line up with the state they describe.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    ack_d   = ack_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    if (pop_s) begin
      {src_d, dst_d, len_d} = head_s;
    end else begin
      {src_d, dst_d, len_d} = {src_q, dst_q, len_q};
    end
    if (bus.err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      S_START: begin
        ack_d = 1'b0;
        tmo_d = {TMO_W{1'b0}};
      end
      S_BUSY: begin
        // Only an idle drop seen during this transfer arms completion, so a
        // done level left over from the previous transfer is ignored.
        ack_d = ack_q || !bus.idle_i;
        if (cpl_s) begin
          tmo_d = tmo_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_hit_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_d;
          end
        end
      end
      default: begin
        ack_d = ack_q;
        tmo_d = tmo_q;
      end
    endcase
    start_d = (state_d == S_START);
    irq_d   = (state_d == S_CPL);
    cmp_d   = (state_d == S_CPL) ? (cmp_q + 8'd1) : cmp_q;
    busy_d  = (state_d != S_IDLE) || (count_d != {CNT_W{1'b0}});
    ready_d = (count_d != CNT_W'(DEPTH));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Latched command, transfer tracking and host-visible output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= {ADDR_W{1'b0}};
      dst_q   <= {ADDR_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      ack_q   <= 1'b0;
      tmo_q   <= {TMO_W{1'b0}};
      err_q   <= 1'b0;
      cmp_q   <= 8'd0;
      start_q <= 1'b0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cmp_q   <= cmp_d;
      start_q <= start_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.cmd_ready_o = ready_q;
  assign bus.start_o     = start_q;
  assign bus.src_addr_o  = src_q;
  assign bus.dst_addr_o  = dst_q;
  assign bus.byte_len_o  = len_q;
  assign bus.busy_o      = busy_q;
  assign bus.irq_o       = irq_q;
  assign bus.cmp_cnt_o   = cmp_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_dma_cmd_issuer.sv
// Scoreboard bench for dma_cmd_issuer: a behavioural BA engine reacts to
// start_o, and every start is checked against the queue of accepted commands.
module tb_dma_cmd_issuer;

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] l;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_cmd_issuer_if #(.ADDR_W(32), .LEN_W(16)) bus ();

  dma_cmd_issuer #(
    .ADDR_W(32), .LEN_W(16), .DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  cmd_t exp_q[$];
  int   start_cnt = 0, irq_cnt = 0, exp_cmp = 0;
  int   last_start_cyc = -100, last_irq_cyc = -100, err_rise_cyc = -1, done_rise_cyc = -1;
  logic prev_start = 1'b0, prev_err = 1'b0;
  int   push_cyc = 0;

  // Engine model knobs.
  int   idle_dly = 2, done_dly = 10;
  bit   eng_respond = 1'b1, eng_hold = 1'b0, eng_active = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // BA engine model: drops idle idle_dly cycles after a start, clears done,
  // then raises done and idle done_dly cycles later.
  initial begin
    int   t;
    logic idle_r, done_r;
    t = 0; idle_r = 1'b1; done_r = 1'b0;
    bus.idle_i = 1'b1;
    bus.done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eng_active = 1'b0; idle_r = 1'b1; done_r = 1'b0;
      end else if (eng_active) begin
        t++;
        if (t == idle_dly) begin
          idle_r = 1'b0; done_r = 1'b0;
        end
        if (t == idle_dly + done_dly) begin
          idle_r = 1'b1; done_r = 1'b1; eng_active = 1'b0; done_rise_cyc = cyc;
        end
      end else if (bus.start_o && eng_respond) begin
        eng_active = 1'b1; t = 0;
      end
      bus.idle_i = idle_r && !eng_hold;
      bus.done_i = done_r;
    end
  end

  // Output monitor and scoreboard.
  initial forever begin
    cmd_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_start = 1'b0; prev_err = 1'b0; exp_cmp = 0;
    end else begin
      if (bus.start_o) begin
        tests++;
        if (prev_start !== 1'b0 || (cyc - last_start_cyc) < 4) begin
          fails++;
          $display("FAIL start_spacing: start at cycle %0d, previous at %0d, required gap >= 4", cyc, last_start_cyc);
        end
        start_cnt++;
        last_start_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL start_unexpected: start_o with src=%h dst=%h len=%h, required no start", bus.src_addr_o, bus.dst_addr_o, bus.byte_len_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.src_addr_o, bus.dst_addr_o, bus.byte_len_o} !== e) begin
            fails++;
            $display("FAIL start_cmd: got src=%h dst=%h len=%h, required src=%h dst=%h len=%h",
                     bus.src_addr_o, bus.dst_addr_o, bus.byte_len_o, e.s, e.d, e.l);
          end
        end
      end
      if (bus.irq_o) begin
        irq_cnt++;
        last_irq_cyc = cyc;
        exp_cmp = (exp_cmp + 1) % 256;
        tests++;
        if (bus.cmp_cnt_o !== 8'(exp_cmp)) begin
          fails++;
          $display("FAIL cmp_cnt: cmp_cnt_o=%0d at irq, required %0d", bus.cmp_cnt_o, exp_cmp);
        end
      end
      if (bus.err_o && !prev_err) err_rise_cyc = cyc;
      prev_start = bus.start_o;
      prev_err   = bus.err_o;
    end
  end

  // Drive one command for one edge; called away from the posedge.
  task automatic push_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          output bit acc);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_src_i   = s;
    bus.cmd_dst_i   = d;
    bus.cmd_len_i   = l;
    acc = bus.cmd_ready_o;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    push_cyc = cyc;
    if (acc && l != 16'd0) exp_q.push_back('{s: s, d: d, l: l});
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy_o || eng_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.busy_o !== 1'b0 || eng_active) begin
      fails++;
      $display("FAIL %s_quiet: busy_o=%b engine_active=%0b after %0d cycles, required 0", tag, bus.busy_o, eng_active, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (bus.start_o !== 1'b0 || bus.irq_o !== 1'b0 || bus.err_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.cmp_cnt_o !== 8'd0 || bus.cmd_ready_o !== 1'b1 || bus.src_addr_o !== 32'd0 ||
        bus.dst_addr_o !== 32'd0 || bus.byte_len_o !== 16'd0) begin
      fails++;
      $display("FAIL %s: start=%b irq=%b err=%b busy=%b cmp=%0d ready=%b src=%h dst=%h len=%h, required 0/0/0/0/0/1/0/0/0",
               tag, bus.start_o, bus.irq_o, bus.err_o, bus.busy_o, bus.cmp_cnt_o, bus.cmd_ready_o,
               bus.src_addr_o, bus.dst_addr_o, bus.byte_len_o);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_src_i   = 32'd0;
    bus.cmd_dst_i   = 32'd0;
    bus.cmd_len_i   = 16'd0;
    bus.err_clr_i   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_single();
    bit acc;
    idle_dly = 2; done_dly = 10;
    push_cmd(32'h100, 32'h200, 16'd16, acc);
    wait_quiet(60, "single");
    tests++;
    if (last_start_cyc !== push_cyc + 2) begin
      fails++;
      $display("FAIL single_latency: start seen at cycle %0d, required %0d", last_start_cyc, push_cyc + 2);
    end
    tests++;
    if (start_cnt !== 1 || irq_cnt !== 1 || bus.cmp_cnt_o !== 8'd1) begin
      fails++;
      $display("FAIL single_counts: starts=%0d irqs=%0d cmp=%0d, required 1/1/1", start_cnt, irq_cnt, bus.cmp_cnt_o);
    end
    tests++;
    if (bus.src_addr_o !== 32'h100 || bus.dst_addr_o !== 32'h200 || bus.byte_len_o !== 16'd16) begin
      fails++;
      $display("FAIL single_hold: src=%h dst=%h len=%h, required 100/200/10", bus.src_addr_o, bus.dst_addr_o, bus.byte_len_o);
    end
  endtask

  task automatic test_stale_done();
    bit acc;
    int s0, i0;
    s0 = start_cnt; i0 = irq_cnt;
    idle_dly = 3; done_dly = 4;
    tests++;
    if (bus.done_i !== 1'b1) begin
      fails++;
      $display("FAIL stale_pre: done_i=%b before start, required 1", bus.done_i);
    end
    push_cmd(32'h1000, 32'h2000, 16'd64, acc);
    wait_quiet(60, "stale");
    tests++;
    if (irq_cnt - i0 !== 1 || start_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL stale_counts: irqs=%0d starts=%0d, required 1/1", irq_cnt - i0, start_cnt - s0);
    end
    tests++;
    if (last_irq_cyc !== done_rise_cyc + 1 || last_irq_cyc <= last_start_cyc + 3) begin
      fails++;
      $display("FAIL stale_irq_time: irq at cycle %0d, required %0d (done rise + 1)", last_irq_cyc, done_rise_cyc + 1);
    end
  endtask

  task automatic test_fifo_full();
    bit acc;
    bit acc_exp[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int s0, i0;
    s0 = start_cnt; i0 = irq_cnt;
    idle_dly = 2; done_dly = 6;
    eng_hold = 1'b1;
    repeat (2) @(negedge clk);
    // Blocker parks the FSM in S_WAIT_IDLE so the next pushes fill the FIFO.
    push_cmd(32'hB00, 32'hC00, 16'd8, acc);
    for (int i = 0; i < 5; i++) begin
      push_cmd(32'h3000 + 32'(i), 32'h4000 + 32'(i), 16'd32 + 16'(i), acc);
      tests++;
      if (acc !== acc_exp[i]) begin
        fails++;
        $display("FAIL full_accept[%0d]: accepted=%0b, required %0b", i, acc, acc_exp[i]);
      end
    end
    tests++;
    if (bus.cmd_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: cmd_ready_o=%b with 4 queued, required 0", bus.cmd_ready_o);
    end
    eng_hold = 1'b0;
    wait_quiet(300, "full");
    tests++;
    if (start_cnt - s0 !== 5 || irq_cnt - i0 !== 5 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL full_counts: starts=%0d irqs=%0d pending=%0d, required 5/5/0", start_cnt - s0, irq_cnt - i0, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    bit acc;
    int s0, i0;
    logic [7:0] c0;
    s0 = start_cnt; i0 = irq_cnt; c0 = bus.cmp_cnt_o;
    idle_dly = 2; done_dly = 5;
    push_cmd(32'h5000, 32'h6000, 16'd8, acc);
    push_cmd(32'h5100, 32'h6100, 16'd0, acc);
    push_cmd(32'h5200, 32'h6200, 16'd4, acc);
    wait_quiet(200, "zero");
    tests++;
    if (start_cnt - s0 !== 2 || irq_cnt - i0 !== 3 || bus.cmp_cnt_o !== c0 + 8'd3) begin
      fails++;
      $display("FAIL zero_counts: starts=%0d irqs=%0d cmp=%0d, required 2/3/%0d", start_cnt - s0, irq_cnt - i0, bus.cmp_cnt_o, c0 + 8'd3);
    end
  endtask

  task automatic test_timeout();
    bit acc;
    int s0, i0, n;
    s0 = start_cnt; i0 = irq_cnt;
    eng_respond = 1'b0;
    push_cmd(32'h7000, 32'h8000, 16'd12, acc);
    n = 0;
    while (bus.err_o !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.err_o !== 1'b1 || err_rise_cyc - last_start_cyc !== 16) begin
      fails++;
      $display("FAIL timeout_err: err_o=%b at %0d cycles after start, required 1 at 16", bus.err_o, err_rise_cyc - last_start_cyc);
    end
    eng_respond = 1'b1;
    idle_dly = 2; done_dly = 5;
    push_cmd(32'h7100, 32'h8100, 16'd12, acc);
    wait_quiet(80, "timeout");
    tests++;
    if (start_cnt - s0 !== 2 || irq_cnt - i0 !== 1 || bus.err_o !== 1'b1) begin
      fails++;
      $display("FAIL timeout_counts: starts=%0d irqs=%0d err=%b, required 2/1/1", start_cnt - s0, irq_cnt - i0, bus.err_o);
    end
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    tests++;
    if (bus.err_o !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: err_o=%b after clear, required 0", bus.err_o);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int s0, i0, n;
    idle_dly = 2; done_dly = 12;
    push_cmd(32'h9000, 32'hA000, 16'd16, acc);
    push_cmd(32'h9100, 32'hA100, 16'd16, acc);
    push_cmd(32'h9200, 32'hA200, 16'd16, acc);
    n = 0;
    while (!eng_active && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    tests++;
    if (bus.busy_o !== 1'b1 || bus.cmd_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: busy=%b ready=%b, required 1/1", bus.busy_o, bus.cmd_ready_o);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_async");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt; i0 = irq_cnt;
    repeat (30) @(negedge clk);
    tests++;
    if (start_cnt !== s0 || irq_cnt !== i0) begin
      fails++;
      $display("FAIL reset_mid_quiet: starts=%0d irqs=%0d after release, required 0/0", start_cnt - s0, irq_cnt - i0);
    end
    check_reset_outputs("reset_mid_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_stale_done();
    test_fifo_full();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
